// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath, memory and next-state block (slave).
interface multicycle_ctrl_if;
  logic [3:0]  next_state;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic        zero;
  logic [3:0]  curr_state;
  logic [1:0]  op;
  logic [2:0]  func_3;
  logic [31:0] ir;
  logic        mem_req;
  logic        mem_we;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic        mem_to_reg;
  logic        bus_err;
  logic        illegal_state;

  modport master (
    input  next_state, instr_in, mem_ready, zero,
    output curr_state, op, func_3, ir, mem_req, mem_we, i_or_d, ir_write,
           pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write,
           mem_to_reg, bus_err, illegal_state
  );

  modport slave (
    output next_state, instr_in, mem_ready, zero,
    input  curr_state, op, func_3, ir, mem_req, mem_we, i_or_d, ir_write,
           pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write,
           mem_to_reg, bus_err, illegal_state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// State register, instruction register, memory-wait/timeout handling and
// Moore control decode for the multicycle core.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADR   = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] EXECUTE_R = 4'd6;
  localparam logic [3:0] ALU_WB    = 4'd7;
  localparam logic [3:0] EXECUTE_I = 4'd8;
  localparam logic [3:0] BNEZ      = 4'd9;

  logic [3:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      ir_q;
  logic             bus_err_q;
  logic             illegal_q;

  logic in_wait;
  logic advance;
  logic timeout;
  logic next_legal;
  logic capture;

  assign in_wait    = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign advance    = !in_wait || bus.mem_ready;
  assign timeout    = in_wait && !bus.mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign next_legal = (bus.next_state <= BNEZ);
  // Strobes are masked while reset is held so an abandoned access never commits.
  assign capture    = (state == FETCH) && bus.mem_ready && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      ir_q      <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (timeout) begin
        state     <= FETCH;
        wait_cnt  <= '0;
        bus_err_q <= 1'b1;
      end else if (advance) begin
        state    <= next_legal ? bus.next_state : FETCH;
        wait_cnt <= '0;
        if (!next_legal) begin
          illegal_q <= 1'b1;
        end
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (capture) begin
        ir_q <= bus.instr_in;
      end
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = capture;
        bus.pc_write  = capture;
      end
      DECODE: begin
        bus.alu_src_b = 2'b10;
      end
      MEM_ADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        bus.mem_req = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      EXECUTE_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      ALU_WB: begin
        bus.reg_write = 1'b1;
      end
      EXECUTE_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
      end
      BNEZ: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 1'b1;
        bus.pc_write  = ~bus.zero;
      end
      default: begin
      end
    endcase
  end

  assign bus.curr_state    = state;
  assign bus.ir            = ir_q;
  assign bus.op            = ir_q[1:0];
  assign bus.func_3        = ir_q[14:12];
  assign bus.bus_err       = bus_err_q;
  assign bus.illegal_state = illegal_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- State register and control-output decoder for the multicycle core.
- Holds `curr_state` and feeds it, with the latched `op`/`func_3`, to the combinational next-state block. Registers the returned `next_state`.
- Drives datapath and memory control signals for each state.
- Owns the instruction register, the memory-wait handshake and the memory timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for `mem_ready` in one memory state before abort; legal range 2..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- next_state  in  4  next state from the next-state block.
- instr_in  in  32  memory read data, captured as the instruction.
- mem_ready  in  1  memory completes the current access this cycle.
- zero  in  1  ALU zero flag; used in BNEZ.
- curr_state  out  4  registered state.
- op  out  2  ir[1:0].
- func_3  out  3  ir[14:12].
- ir  out  32  instruction register.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid with `mem_req`.
- i_or_d  out  1  address select: 0 = PC, 1 = ALU out.
- ir_write  out  1  instruction capture strobe.
- pc_write  out  1  PC update enable.
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALU out (branch target).
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = R-type, 11 = I-type.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back source: 0 = ALU, 1 = MDR.
- bus_err  out  1  sticky memory timeout flag.
- illegal_state  out  1  sticky flag: an unencoded `next_state` was received.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE_R=6, ALU_WB=7, EXECUTE_I=8, BNEZ=9.
- Reset (asynchronous, rst_n=0): `curr_state`=FETCH, `ir`=0, wait counter=0, `bus_err`=0, `illegal_state`=0.
  - All control outputs follow the decode of FETCH, gated by `mem_ready`.
  - Reset mid-access abandons the access; no `pc_write`/`ir_write` is generated after reset assertion.
- Wait states are FETCH, MEM_READ and MEM_WRITE. In a wait state, `curr_state` holds while `mem_ready`=0 and loads `next_state` on the cycle `mem_ready`=1.
- In every other state, `curr_state` loads `next_state` every cycle (single-cycle states).
- If `next_state` is 10..15: load FETCH instead and set `illegal_state`.
- Wait counter:
  - Increments each cycle in a wait state with `mem_ready`=0.
  - Clears on any state change.
  - When the counter equals MEM_TIMEOUT-1 and `mem_ready` is still 0:
    - next state forced to FETCH, `bus_err` set, no strobes issued;
    - a timeout in FETCH re-enters FETCH with the counter cleared.
- Output decode: Moore on `curr_state`, except strobes gated as noted. All unlisted outputs are 0.
  - FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=0; `ir_write`=`pc_write`=`mem_ready`.
  - `ir` loads `instr_in` on the same edge.
  - DECODE: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=00 (branch target precompute).
  - MEM_ADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEM_READ: `mem_req`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1.
  - MEM_WRITE: `mem_req`=1, `mem_we`=1, `i_or_d`=1.
  - EXECUTE_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - EXECUTE_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11.
  - ALU_WB: `reg_write`=1, `mem_to_reg`=0.
  - BNEZ: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=1, `pc_write`=~`zero`.
- `op`/`func_3` change only on the `ir_write` edge; stable through the rest of the instruction.
- `mem_ready` outside wait states is ignored.
- `bus_err` and `illegal_state` clear only on reset.

Test Plan:
- Reset release, `mem_ready`=1, `instr_in`=0x00000000, loopback to the next-state block:
  - cycle 1: FETCH with `ir_write`=`pc_write`=1;
  - then DECODE, then EXECUTE_R, then ALU_WB with `reg_write`=1, then FETCH.
- Load: `instr_in`=0x00000002 (op=10, func_3=000), `mem_ready`=1:
  - sequence FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB;
  - MEM_READ shows `mem_req`=1, `i_or_d`=1;
  - MEM_WB shows `mem_to_reg`=1.
- Store with `mem_ready` low 3 cycles in MEM_WRITE: `curr_state`=5 for 4 cycles with `mem_we`=1, then FETCH; `bus_err`=0.
- Timeout: `mem_ready`=0 for 16 cycles in MEM_READ → FETCH on cycle 17, `bus_err`=1 and remains 1; no `reg_write` pulse.
- BNEZ: `instr_in`=0x00000003, `zero`=0 → `pc_write`=1, `pc_src`=1; repeat with `zero`=1 → `pc_write`=0.
- Force `next_state`=4'b1100 in DECODE → next cycle FETCH, `illegal_state`=1. Assert `rst_n`=0 mid-MEM_READ → immediate FETCH, flags cleared.
